icache_data_array: RTL and testbench
====================================

// Module: icache_data_array
// PURPOSE
//  Data storage for the direct-mapped instruction cache: 64 lines x 4 words x 32 bits (1 KiB).
//  Asynchronous word read, addressed by {index, offset}, serves the fetch path in the same cycle.
//  Synchronous single-word write is driven by the refill FSM, one word per clock during line fill.
//  Tags and valid bits are held elsewhere; this block holds data only.
// PARAMETERS
//  DATA_WIDTH      32  bits per word
//  INDEX_WIDTH     6   line-index bits (NUM_LINES = 2**INDEX_WIDTH = 64)
//  OFFSET_WIDTH    2   word-offset bits (WORDS_PER_LINE = 2**OFFSET_WIDTH = 4)
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  rst_n          in   1   reset, synchronous, active-HIGH (1 = reset); sampled on clk rising edge
//  read_index     in   6   line index for read
//  read_offset    in   2   word offset within line for read
//  read_data      out  32  word at {read_index, read_offset}, combinational
//  write_enable   in   1   1 = write write_data at rising edge
//  write_index    in   6   line index for write
//  write_offset   in   2   word offset for write
//  write_data     in   32  word to store
// BEHAVIOUR
//  - Storage: 256 x 32 array; word address = {index, offset} = index*4 + offset; no aliasing between lines.
//  - Read: purely combinational, zero cycle latency; read_data follows read_index/read_offset and
//    array contents with no clock dependency; no read enable.
//  - Write: at clk rising edge, if write_enable=1 and reset not asserted, mem[{write_index,write_offset}]
//    <= write_data; exactly one word changes; all other words hold.
//  - write_enable=0: array unchanged regardless of write_index/offset/data.
//  - Reset (rst_n=1 at rising edge): all 256 words cleared to 32'h0 in that edge; write_enable ignored
//    in reset cycles; reset may assert mid-fill, discarding any partial line (all zero afterwards).
//  - read_data after reset = 32'h0 for every address until written; no X ever driven after first reset.
//  - Read/write same address same cycle: read_data shows OLD value until the edge, NEW value right
//    after the edge (no write-through bypass).
//  - Read/write different addresses same cycle: fully independent; read unaffected by the write.
//  - Back-to-back writes on consecutive cycles allowed; last write to an address wins.
//  - Index 0 and index 63 boundaries behave identically to all others; no wrap-around logic needed.
//  - No handshake, no stall, no error outputs.
// TESTING
//  1. Reset, then write idx5/off2=DEADBEEF, drop enable -> read idx5/off2 returns 32'hDEADBEEF.
//  2. Fill idx10 off0..3 with 1000_0000,1000_0100,1000_0200,1000_0300 -> each offset reads its value.
//  3. Lines 0..7, all offsets, data {idx[5:0],10'h0,off[1:0],14'h0} -> all 32 words read back exactly.
//  4. idx20/off1 write AAAAAAAA then BBBBBBBB -> reads 32'hBBBBBBBB; neighbouring offsets unchanged.
//  5. idx0 off i = i, idx63 off i = 3F00_000i for i=0..3 -> no cross-line corruption at boundaries.
//  6. Write idx30/off3=CAFEBABE while reading idx10/off0 -> read stays 32'h1000_0000 through edge;
//     then reset -> all reads 0; same-address read shows old value before edge, new after.

Source files
------------

// File: rtl/icache_data_array.sv
// Instruction-cache data storage: 64 lines x 4 words x 32 bits, held as a flat
// 256-word array addressed by {index, offset}.
//
// Ports:
//   clk           - single clock, all state updates on the rising edge
//   rst_n         - synchronous reset, active HIGH despite the name (1 = clear all words)
//   read_index    - line index for the fetch-path read
//   read_offset   - word offset within the line for the read
//   read_data     - combinational word at {read_index, read_offset}
//   write_enable  - 1 = store write_data at the rising edge
//   write_index   - line index for the refill write
//   write_offset  - word offset for the refill write
//   write_data    - word to store
module icache_data_array #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH  = 6,
    parameter int unsigned OFFSET_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INDEX_WIDTH-1:0]  read_index,
    input  logic [OFFSET_WIDTH-1:0] read_offset,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    write_enable,
    input  logic [INDEX_WIDTH-1:0]  write_index,
    input  logic [OFFSET_WIDTH-1:0] write_offset,
    input  logic [DATA_WIDTH-1:0]   write_data
);

    localparam int unsigned AddrWidth = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int unsigned NumWords  = 2 ** AddrWidth;

    logic [DATA_WIDTH-1:0] mem_q [NumWords];
    logic [DATA_WIDTH-1:0] mem_d [NumWords];

    logic [AddrWidth-1:0] read_addr;
    logic [AddrWidth-1:0] write_addr;

    assign read_addr  = {read_index, read_offset};
    assign write_addr = {write_index, write_offset};

    // Read straight from the registered array: no bypass, so a same-address
    // write only becomes visible after the edge that commits it.
    assign read_data = mem_q[read_addr];

    always_comb begin
        mem_d = mem_q;
        if (write_enable) begin
            mem_d[write_addr] = write_data;
        end
    end

    // Reset wins over a concurrent write, which discards any partial line fill.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_icache_data_array.sv
module tb_icache_data_array;

    logic        clk;
    logic        rst_n;
    logic [5:0]  read_index;
    logic [1:0]  read_offset;
    logic [31:0] read_data;
    logic        write_enable;
    logic [5:0]  write_index;
    logic [1:0]  write_offset;
    logic [31:0] write_data;

    int n_cmp  = 0;
    int n_fail = 0;

    icache_data_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_index   (read_index),
        .read_offset  (read_offset),
        .read_data    (read_data),
        .write_enable (write_enable),
        .write_index  (write_index),
        .write_offset (write_offset),
        .write_data   (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain 256-entry word array indexed by index*4 + offset.
    logic [31:0] model [256];
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 256; i++) model[i] <= 32'h0;
            started <= 1'b1;
        end else if (write_enable) begin
            model[int'(write_index) * 4 + int'(write_offset)] <= write_data;
        end
    end

    // Every falling edge after the first reset the read port must match the model.
    always @(negedge clk) begin
        if (started) begin
            n_cmp++;
            if (read_data !== model[int'(read_index) * 4 + int'(read_offset)]) begin
                n_fail++;
                $display("FAIL cycle_read t=%0t idx=%0d off=%0d got=%h want=%h", $time,
                         read_index, read_offset, read_data,
                         model[int'(read_index) * 4 + int'(read_offset)]);
            end
        end
    end

    task automatic wr(input logic [5:0] idx, input logic [1:0] off, input logic [31:0] data);
        write_enable = 1'b1;
        write_index  = idx;
        write_offset = off;
        write_data   = data;
        @(posedge clk);
        #2;
        write_enable = 1'b0;
    endtask

    // Literal check of both the DUT and the model against a hand-computed value.
    task automatic chk(input string name, input logic [5:0] idx, input logic [1:0] off,
                       input logic [31:0] exp);
        read_index  = idx;
        read_offset = off;
        #1;
        n_cmp++;
        if (read_data !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d off=%0d got=%h want=%h", name, idx, off, read_data, exp);
        end
        n_cmp++;
        if (model[int'(idx) * 4 + int'(off)] !== exp) begin
            n_fail++;
            $display("FAIL %s_model idx=%0d off=%0d got=%h want=%h", name, idx, off,
                     model[int'(idx) * 4 + int'(off)], exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b1;
        read_index   = '0;
        read_offset  = '0;
        write_enable = 1'b0;
        write_index  = '0;
        write_offset = '0;
        write_data   = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;

        chk("reset_zero_0", 6'd0, 2'd0, 32'h0);
        chk("reset_zero_63", 6'd63, 2'd3, 32'h0);

        // 1: single write
        wr(6'd5, 2'd2, 32'hDEADBEEF);
        chk("single_write", 6'd5, 2'd2, 32'hDEADBEEF);

        // 2: line fill
        for (int i = 0; i < 4; i++) wr(6'd10, 2'(i), 32'h1000_0000 + 32'(i) * 32'h100);
        chk("fill_off0", 6'd10, 2'd0, 32'h1000_0000);
        chk("fill_off1", 6'd10, 2'd1, 32'h1000_0100);
        chk("fill_off2", 6'd10, 2'd2, 32'h1000_0200);
        chk("fill_off3", 6'd10, 2'd3, 32'h1000_0300);

        // 3: lines 0..7 with address-derived pattern
        for (int l = 0; l < 8; l++)
            for (int o = 0; o < 4; o++)
                wr(6'(l), 2'(o), {6'(l), 10'h0, 2'(o), 14'h0});
        for (int l = 0; l < 8; l++)
            for (int o = 0; o < 4; o++)
                chk("pattern", 6'(l), 2'(o), (32'(l) << 26) | (32'(o) << 14));

        // 4: overwrite, last write wins
        wr(6'd20, 2'd1, 32'hAAAAAAAA);
        wr(6'd20, 2'd1, 32'hBBBBBBBB);
        chk("overwrite", 6'd20, 2'd1, 32'hBBBBBBBB);
        chk("neighbour_off0", 6'd20, 2'd0, 32'h0);
        chk("neighbour_off2", 6'd20, 2'd2, 32'h0);

        // 5: boundary lines
        for (int i = 0; i < 4; i++) begin
            wr(6'd0, 2'(i), 32'(i));
            wr(6'd63, 2'(i), 32'h3F00_0000 + 32'(i));
        end
        chk("idx0_off3", 6'd0, 2'd3, 32'h3);
        chk("idx63_off0", 6'd63, 2'd0, 32'h3F00_0000);
        chk("idx63_off3", 6'd63, 2'd3, 32'h3F00_0003);
        chk("idx1_intact", 6'd1, 2'd0, 32'h0400_0000);

        // 6: read one address while writing another
        read_index   = 6'd10;
        read_offset  = 2'd0;
        write_enable = 1'b1;
        write_index  = 6'd30;
        write_offset = 2'd3;
        write_data   = 32'hCAFEBABE;
        chk("indep_before", 6'd10, 2'd0, 32'h1000_0000);
        @(posedge clk);
        chk("indep_after", 6'd10, 2'd0, 32'h1000_0000);
        write_enable = 1'b0;
        chk("indep_written", 6'd30, 2'd3, 32'hCAFEBABE);

        // Reset with a write pending: write is discarded, everything clears
        write_enable = 1'b1;
        write_index  = 6'd40;
        write_offset = 2'd1;
        write_data   = 32'h5555_5555;
        do_reset();
        write_enable = 1'b0;
        chk("rst_clear_5", 6'd5, 2'd2, 32'h0);
        chk("rst_clear_30", 6'd30, 2'd3, 32'h0);
        chk("rst_drop_write", 6'd40, 2'd1, 32'h0);

        // Same-address read/write: old value until the edge, new after
        write_enable = 1'b1;
        write_index  = 6'd7;
        write_offset = 2'd1;
        write_data   = 32'h1234_5678;
        chk("same_addr_old", 6'd7, 2'd1, 32'h0);
        @(posedge clk);
        chk("same_addr_new", 6'd7, 2'd1, 32'h1234_5678);
        write_enable = 1'b0;
        @(posedge clk);
        #2;

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 299) == 0);
            write_enable = $urandom_range(0, 1);
            write_index  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 6'd63 : 6'd0)
                                                       : 6'($urandom);
            write_offset = 2'($urandom);
            write_data   = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                read_index  = write_index;
                read_offset = write_offset;
            end else begin
                read_index  = 6'($urandom_range(0, 15));
                read_offset = 2'($urandom);
            end
            @(posedge clk);
            #2;
        end
        rst_n        = 1'b0;
        write_enable = 1'b0;
        @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
